reg_readout_serializer: RTL

//  Read side of the 6-bit result register path: accepts parallel register words, buffers them
//  in a small FIFO, transmits each MSB-first on a 1-bit serial line with a frame strobe.

---
 rtl/reg_readout_serializer_if.sv | 12 +
 rtl/reg_readout_serializer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/reg_readout_serializer_if.sv
// Parallel write-side handshake of the result-register readout serializer.
// master offers words (wr_valid/wr_data); slave answers with wr_ready.
interface reg_readout_serializer_if #(
  parameter int WIDTH = 6
);
  logic             wr_valid;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/reg_readout_serializer.sv
// Buffers parallel result words in a small FIFO and shifts each out MSB-first with a frame strobe.
// Optional feature macro: PARITY_EN appends an even-parity bit to every frame.
module reg_readout_serializer #(
  parameter int WIDTH  = 6,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  reg_readout_serializer_if.slave wr,
  input  logic                    tx_en,
  output logic                    sout,
  output logic                    sframe,
  output logic                    busy,
  output logic [ADDR_W:0]         count
);

  localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  // Each state names the step whose output is being registered onto sout at the
  // coming edge, so the one-cycle gap is visible while the FSM is already IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
`ifdef PARITY_EN
    PAR   = 2'd2,
`endif
    GAP   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [WIDTH-1:0]  shreg_reg;
  logic [CW-1:0]     bit_reg;
  logic              sout_reg, sout_next;
  logic              sframe_reg, sframe_next;
`ifdef PARITY_EN
  logic              par_reg;
`endif

  logic             wr_ready_int;
  logic             push, pop;
  logic [WIDTH-1:0] head_word;

  assign wr_ready_int = (count_reg != FULL);
  assign wr.wr_ready  = wr_ready_int;
  assign push         = wr.wr_valid & wr_ready_int;
  assign pop          = (state_reg == IDLE) & tx_en & (count_reg != '0);
  assign head_word    = mem[rd_ptr_reg];

  assign sout   = sout_reg;
  assign sframe = sframe_reg;
  assign busy   = (state_reg != IDLE);
  assign count  = count_reg;

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (pop) state_next = SHIFT;
`ifdef PARITY_EN
      SHIFT: if (bit_reg == CW'(1)) state_next = PAR;
      PAR:   state_next = GAP;
`else
      SHIFT: if (bit_reg == CW'(1)) state_next = GAP;
`endif
      GAP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sout_next   = 1'b0;
    sframe_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          sout_next   = head_word[WIDTH-1];
          sframe_next = 1'b1;
        end
      end
      SHIFT: begin
        sout_next   = shreg_reg[bit_reg - CW'(1)];
        sframe_next = 1'b1;
      end
`ifdef PARITY_EN
      PAR: begin
        sout_next   = par_reg;
        sframe_next = 1'b1;
      end
`endif
      default: begin
        sout_next   = 1'b0;
        sframe_next = 1'b0;
      end
    endcase
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      shreg_reg  <= '0;
      bit_reg    <= '0;
      sout_reg   <= 1'b0;
      sframe_reg <= 1'b0;
`ifdef PARITY_EN
      par_reg    <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      sout_reg   <= sout_next;
      sframe_reg <= sframe_next;
      if (pop) begin
        shreg_reg <= head_word;
        bit_reg   <= CW'(WIDTH-1);
`ifdef PARITY_EN
        par_reg   <= ^head_word;
`endif
      end else if (state_reg == SHIFT) begin
        bit_reg <= bit_reg - CW'(1);
      end
    end
  end

endmodule
